// File: rtl/stopwatch_timebase_ctrl_if.sv
// Mode-level inputs from the button handler and registered BCD display outputs
// of the stopwatch timebase controller, with master (driver) and slave (controller) views.
interface stopwatch_timebase_ctrl_if;
  logic       clear;
  logic       prepare_start;
  logic       running;
  logic       lap;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;
  logic       overflow;
  logic       lap_active;

  modport master (
    output clear, prepare_start, running, lap,
    input  disp_min, disp_sec, disp_cs, overflow, lap_active
  );

  modport slave (
    input  clear, prepare_start, running, lap,
    output disp_min, disp_sec, disp_cs, overflow, lap_active
  );
endinterface

// File: rtl/stopwatch_timebase_ctrl.sv
// Stopwatch timebase: prescaler, saturating BCD mm:ss.cc counter and display registers.
// Optional lap-hold display freeze is built only when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_timebase_ctrl #(
  parameter int TICK_DIV = 500_000
) (
  input logic                       clk,
  input logic                       rst_n,
  stopwatch_timebase_ctrl_if.slave  bus
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  // Digit order from MSB: min tens, min units, sec tens, sec units, cs tens, cs units
  localparam logic [23:0]     CNT_MAX    = 24'h59_5999;

  typedef enum logic [2:0] {IDLE, ARMED, COUNT, PAUSED, HALT} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [23:0]   cnt_q;
  logic [23:0]   disp_q;
  logic          ovf_q;
  logic          hold_q;

  logic          tick_d;
  logic [PW-1:0] presc_d;
  logic [23:0]   cnt_d;

  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] n;
    logic        cy;
    logic [3:0]  lim;
    n  = c;
    cy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (cy) begin
        if (n[i*4 +: 4] >= lim) begin
          n[i*4 +: 4] = 4'd0;
        end else begin
          n[i*4 +: 4] = n[i*4 +: 4] + 4'd1;
          cy          = 1'b0;
        end
      end
    end
    return n;
  endfunction

  assign tick_d  = (state_q == COUNT) && (presc_q == PRESC_LAST);
  assign presc_d = tick_d ? '0 : presc_q + PW'(1);
  assign cnt_d   = bcd_inc(cnt_q);

`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_tgl;
  assign lap_tgl = bus.lap && (state_q == COUNT || state_q == PAUSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else if (bus.clear) begin
      hold_q <= 1'b0;
    end else if (lap_tgl) begin
      hold_q <= !hold_q;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign hold_q     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // The hold flag is sampled before its own update, so the entering cycle still captures
      if (!hold_q) disp_q <= cnt_q;
      if (bus.clear) begin
        state_q <= IDLE;
        presc_q <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            presc_q <= '0;
            if (bus.prepare_start)  state_q <= ARMED;
            else if (bus.running)   state_q <= COUNT;
          end
          ARMED: begin
            presc_q <= '0;
            if (!bus.prepare_start && bus.running) state_q <= COUNT;
          end
          COUNT: begin
            if (tick_d && cnt_q == CNT_MAX) begin
              ovf_q   <= 1'b1;
              presc_q <= '0;
              state_q <= HALT;
            end else begin
              presc_q <= presc_d;
              if (tick_d) cnt_q <= cnt_d;
              // A tick landing on the same cycle as a mode change is still applied
              if (bus.prepare_start) begin
                presc_q <= '0;
                state_q <= ARMED;
              end else if (!bus.running) begin
                state_q <= PAUSED;
              end
            end
          end
          PAUSED: begin
            if (bus.prepare_start) begin
              presc_q <= '0;
              state_q <= ARMED;
            end else if (bus.running) begin
              state_q <= COUNT;
            end
          end
          HALT: begin
            state_q <= HALT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.disp_min   = disp_q[23:16];
  assign bus.disp_sec   = disp_q[15:8];
  assign bus.disp_cs    = disp_q[7:0];
  assign bus.overflow   = ovf_q;
  assign bus.lap_active = hold_q;

endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// Directed table-driven bench for stopwatch_timebase_ctrl with TICK_DIV=4; a few
// hand-written sequences cover the overflow preload and asynchronous reset.
module tb_stopwatch_timebase_ctrl;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst_n;

  stopwatch_timebase_ctrl_if sw();

  stopwatch_timebase_ctrl #(.TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       prep;
    logic       run;
    logic       lap;
    int         cyc;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [7:0] cs;
    logic       ovf;
    logic       la;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   pre_idx;

  function automatic void add(input logic c, input logic p, input logic r, input logic l,
                              input int n, input logic [7:0] mn, input logic [7:0] sc,
                              input logic [7:0] cs, input logic o, input logic la);
    vec_t v;
    v.clr = c; v.prep = p; v.run = r; v.lap = l; v.cyc = n;
    v.mn = mn; v.sc = sc; v.cs = cs; v.ovf = o; v.la = la;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic [7:0] mn, input logic [7:0] sc,
                           input logic [7:0] cs, input logic o, input logic la);
    chk("disp_min",   idx, sw.disp_min, mn);
    chk("disp_sec",   idx, sw.disp_sec, sc);
    chk("disp_cs",    idx, sw.disp_cs,  cs);
    chk("overflow",   idx, {7'd0, sw.overflow},   {7'd0, o});
    chk("lap_active", idx, {7'd0, sw.lap_active}, {7'd0, la});
  endtask

  task automatic drive(input logic c, input logic p, input logic r, input logic l);
    sw.clear         = c;
    sw.prepare_start = p;
    sw.running       = r;
    sw.lap           = l;
  endtask

  task automatic run_vec(input int i);
    drive(tbl[i].clr, tbl[i].prep, tbl[i].run, tbl[i].lap);
    repeat (tbl[i].cyc) @(posedge clk);
    @(negedge clk);
    check_out(i, tbl[i].mn, tbl[i].sc, tbl[i].cs, tbl[i].ovf, tbl[i].la);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    //   clr prep run lap  cycles  min    sec    cs    ovf lap_active
    add(0, 0, 0, 0, 2,     8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 0, 3,     8'h00, 8'h00, 8'h00, 0, 0);  // ARMED
    add(0, 0, 1, 0, 1,     8'h00, 8'h00, 8'h00, 0, 0);  // enter COUNT
    add(0, 0, 1, 0, 601,   8'h00, 8'h01, 8'h50, 0, 0);  // 150 ticks + 1 display cycle
    add(1, 0, 0, 0, 1,     8'h00, 8'h01, 8'h50, 0, 0);  // display lags the cleared counter
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h00, 0, 0);
    // pause/resume: prescaler parks at 2 and finishes the interval after resume
    add(0, 0, 1, 0, 6,     8'h00, 8'h00, 8'h01, 0, 0);
    add(0, 0, 0, 0, 20,    8'h00, 8'h00, 8'h01, 0, 0);
    add(0, 0, 1, 0, 2,     8'h00, 8'h00, 8'h01, 0, 0);
    add(0, 0, 1, 0, 1,     8'h00, 8'h00, 8'h01, 0, 0);
    add(0, 0, 1, 0, 1,     8'h00, 8'h00, 8'h02, 0, 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    add(0, 0, 1, 1, 1,     8'h00, 8'h00, 8'h02, 0, 1);
    add(0, 0, 1, 0, 3,     8'h00, 8'h00, 8'h02, 0, 1);  // frozen while counter reaches 03
`else
    add(0, 0, 1, 1, 1,     8'h00, 8'h00, 8'h02, 0, 0);
    add(0, 0, 1, 0, 3,     8'h00, 8'h00, 8'h03, 0, 0);
`endif
    // priority
    add(1, 0, 1, 0, 10,    8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 1, 1, 0, 3,     8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 1, 1, 0, 10,    8'h00, 8'h00, 8'h00, 0, 0);  // ARMED beats running
    // carry chain to one minute
    add(0, 0, 1, 0, 23998, 8'h00, 8'h59, 8'h99, 0, 0);
    add(0, 0, 1, 0, 3,     8'h00, 8'h59, 8'h99, 0, 0);
    add(0, 0, 1, 0, 1,     8'h01, 8'h00, 8'h00, 0, 0);
    add(0, 0, 0, 0, 2,     8'h01, 8'h00, 8'h00, 0, 0);  // PAUSED
    add(0, 1, 0, 0, 1,     8'h01, 8'h00, 8'h00, 0, 0);  // ARMED keeps the count
    pre_idx = tbl.size();
    // after preload of 59:59.98 in ARMED
    add(0, 0, 1, 0, 6,     8'h59, 8'h59, 8'h99, 0, 0);
    add(0, 0, 1, 0, 2,     8'h59, 8'h59, 8'h99, 0, 0);
    add(0, 0, 1, 0, 1,     8'h59, 8'h59, 8'h99, 1, 0);  // saturating tick
    add(0, 0, 0, 0, 5,     8'h59, 8'h59, 8'h99, 1, 0);
    add(0, 0, 1, 0, 20,    8'h59, 8'h59, 8'h99, 1, 0);
    add(0, 1, 0, 0, 5,     8'h59, 8'h59, 8'h99, 1, 0);
    add(1, 0, 0, 0, 1,     8'h59, 8'h59, 8'h99, 0, 0);
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h00, 0, 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    add(0, 0, 0, 1, 1,     8'h00, 8'h00, 8'h00, 0, 0);  // ignored in IDLE
    add(0, 0, 1, 0, 42,    8'h00, 8'h00, 8'h10, 0, 0);
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h10, 0, 0);
    add(0, 0, 0, 1, 1,     8'h00, 8'h00, 8'h10, 0, 1);
    add(0, 0, 1, 0, 119,   8'h00, 8'h00, 8'h10, 0, 1);  // counter now 00:00.40
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h10, 0, 1);
    add(0, 0, 0, 1, 1,     8'h00, 8'h00, 8'h10, 0, 0);
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h40, 0, 0);
    add(1, 0, 0, 0, 1,     8'h00, 8'h00, 8'h40, 0, 0);
    add(0, 0, 0, 0, 1,     8'h00, 8'h00, 8'h00, 0, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out(-1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < pre_idx; i++) run_vec(i);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    force dut.cnt_q = 24'h59_5998;
    @(posedge clk);
    @(negedge clk);
    release dut.cnt_q;
    check_out(100, 8'h59, 8'h59, 8'h98, 1'b0, 1'b0);

    for (int i = pre_idx; i < tbl.size(); i++) run_vec(i);

    // asynchronous reset in the middle of counting
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("disp_cs", 200, sw.disp_cs, 8'h02);
    rst_n = 1'b0;
    #1;
    check_out(201, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_out(202, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
